aes_round_sequencer: RTL and testbench

//  Sequences the dual-rail AES-256 datapath (AddRoundKey/SubBytes/ShiftRows/MixColumns, T/F rails) through 1 initial + NR rounds.

---
 rtl/aes_round_sequencer.sv | 174 +++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Precharge/evaluate round sequencer for a dual-rail AES-256 datapath: round 0 plus NR full rounds.
// Define SPACER_CHECK_EN to build the sticky rail-protocol checker driving err_o.
module aes_round_sequencer #(
   parameter int N        = 128,
   parameter int NR       = 14,
   parameter int PRE_CYC  = 1,
   parameter int EVAL_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         precharge_o,
   output logic         eval_o,
   output logic [3:0]   round_o,
   output logic [3:0]   key_sel_o,
   output logic         sel_init_o,
   output logic         last_round_o,
   output logic         state_we_o,
   output logic         done_o,
   input  logic [N-1:0] dr_t_i,
   input  logic [N-1:0] dr_f_i,
   output logic         err_o
);

   localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
   localparam int PW      = $clog2(MAX_CYC) + 1;
   localparam logic [PW-1:0] PRE_LAST   = PW'(PRE_CYC - 1);
   localparam logic [PW-1:0] EVAL_LAST  = PW'(EVAL_CYC - 1);
   localparam logic [3:0]    ROUND_LAST = 4'(NR);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_EVAL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state_reg, state_next;
   logic [PW-1:0]  phase_reg, phase_next;
   logic [3:0]     round_reg, round_next;

   logic ready_reg, ready_next;
   logic busy_reg, busy_next;
   logic precharge_reg, precharge_next;
   logic eval_reg, eval_next;
   logic sel_init_reg, sel_init_next;
   logic last_round_reg, last_round_next;
   logic state_we_reg, state_we_next;
   logic done_reg, done_next;

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      round_next = round_reg;
      case (state_reg)
         S_IDLE: begin
            if (start_i) begin
               state_next = S_PRE;
               phase_next = '0;
               round_next = 4'd0;
            end
         end
         S_PRE: begin
            if (phase_reg == PRE_LAST) begin
               state_next = S_EVAL;
               phase_next = '0;
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         S_EVAL: begin
            if (phase_reg == EVAL_LAST) begin
               phase_next = '0;
               if (round_reg == ROUND_LAST) begin
                  state_next = S_DONE;
               end else begin
                  state_next = S_PRE;
                  round_next = round_reg + 4'd1;
               end
            end else begin
               phase_next = phase_reg + 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
            phase_next = '0;
            round_next = 4'd0;
         end
      endcase
   end

   // Outputs are decoded from the next-state values and registered, so they
   // line up with the state they describe and have no path from start_i.
   always_comb begin
      ready_next      = (state_next == S_IDLE);
      busy_next       = (state_next != S_IDLE);
      precharge_next  = (state_next != S_EVAL);
      eval_next       = (state_next == S_EVAL);
      state_we_next   = (state_next == S_EVAL) && (phase_next == EVAL_LAST);
      done_next       = (state_next == S_DONE);
      sel_init_next   = busy_next && (round_next == 4'd0);
      last_round_next = busy_next && (round_next == ROUND_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         phase_reg      <= '0;
         round_reg      <= 4'd0;
         ready_reg      <= 1'b1;
         busy_reg       <= 1'b0;
         precharge_reg  <= 1'b1;
         eval_reg       <= 1'b0;
         sel_init_reg   <= 1'b0;
         last_round_reg <= 1'b0;
         state_we_reg   <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         phase_reg      <= phase_next;
         round_reg      <= round_next;
         ready_reg      <= ready_next;
         busy_reg       <= busy_next;
         precharge_reg  <= precharge_next;
         eval_reg       <= eval_next;
         sel_init_reg   <= sel_init_next;
         last_round_reg <= last_round_next;
         state_we_reg   <= state_we_next;
         done_reg       <= done_next;
      end
   end

   assign ready_o      = ready_reg;
   assign busy_o       = busy_reg;
   assign precharge_o  = precharge_reg;
   assign eval_o       = eval_reg;
   assign round_o      = round_reg;
   assign key_sel_o    = round_reg;
   assign sel_init_o   = sel_init_reg;
   assign last_round_o = last_round_reg;
   assign state_we_o   = state_we_reg;
   assign done_o       = done_reg;

`ifdef SPACER_CHECK_EN
   logic err_reg;
   logic pre_last_cyc;
   logic eval_last_cyc;
   logic spacer_bad;
   logic codeword_bad;

   // The rails are judged at the end of each phase, once they have settled.
   assign pre_last_cyc  = (state_reg == S_PRE)  && (phase_reg == PRE_LAST);
   assign eval_last_cyc = (state_reg == S_EVAL) && (phase_reg == EVAL_LAST);
   assign spacer_bad    = |(dr_t_i | dr_f_i);
   assign codeword_bad  = (|(dr_t_i & dr_f_i)) || (|(~(dr_t_i | dr_f_i)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if ((pre_last_cyc && spacer_bad) || (eval_last_cyc && codeword_bad)) begin
         err_reg <= 1'b1;
      end
   end

   assign err_o = err_reg;
`else
   logic unused_rails;
   assign unused_rails = ^{dr_t_i, dr_f_i};
   assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: default and stretched-phase instances, hand-derived cycle timelines.
module tb_aes_round_sequencer;

   logic         clk;
   logic         rst;
   logic         start;
   logic         start2;
   logic [127:0] dr_t;
   logic [127:0] dr_f;
   logic [127:0] pat;

   logic       ready, busy, precharge, eval_s, sel_init, last_round, state_we, done, err;
   logic [3:0] round, key_sel;
   logic       ready2, busy2, precharge2, eval2, sel_init2, last_round2, state_we2, done2, err2;
   logic [3:0] round2, key_sel2;

   int checks = 0;
   int errors = 0;

   aes_round_sequencer dut (
      .clk(clk), .rst(rst), .start_i(start),
      .ready_o(ready), .busy_o(busy), .precharge_o(precharge), .eval_o(eval_s),
      .round_o(round), .key_sel_o(key_sel), .sel_init_o(sel_init), .last_round_o(last_round),
      .state_we_o(state_we), .done_o(done),
      .dr_t_i(dr_t), .dr_f_i(dr_f), .err_o(err)
   );

   aes_round_sequencer #(.N(128), .NR(14), .PRE_CYC(2), .EVAL_CYC(3)) dut2 (
      .clk(clk), .rst(rst), .start_i(start2),
      .ready_o(ready2), .busy_o(busy2), .precharge_o(precharge2), .eval_o(eval2),
      .round_o(round2), .key_sel_o(key_sel2), .sel_init_o(sel_init2), .last_round_o(last_round2),
      .state_we_o(state_we2), .done_o(done2),
      .dr_t_i(dr_t), .dr_f_i(dr_f), .err_o(err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start2 = 1'b0; dr_t = '0; dr_f = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ready, precharge, busy, done, eval_s, state_we, err} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_flags: got rdy/pre/busy/done/eval/we/err=%b, want 1100000",
                  {ready, precharge, busy, done, eval_s, state_we, err});
      end
      checks++;
      if (round !== 4'd0 || sel_init !== 1'b0 || last_round !== 1'b0) begin
         errors++;
         $display("FAIL reset_round: got round=%0d sel_init=%b last=%b, want 0 0 0",
                  round, sel_init, last_round);
      end
      $display("reset: ready=%b precharge=%b round=%0d", ready, precharge, round);
   endtask

   task automatic test_single_run();
      int we_cnt = 0;
      int done_cyc = -1;
      logic [3:0] exp_round;
      logic exp_eval, exp_done, exp_sel, exp_last;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 1; n <= 33; n++) begin
         exp_round = (n <= 30) ? 4'((n - 1) / 2) : ((n == 31) ? 4'd14 : 4'd0);
         exp_eval  = (n <= 30) && (n % 2 == 0);
         exp_done  = (n == 31);
         exp_sel   = (n <= 2);
         exp_last  = (n >= 29) && (n <= 31);
         checks++;
         if (round !== exp_round || key_sel !== exp_round) begin
            errors++;
            $display("FAIL single_round c%0d: got round=%0d key=%0d, want %0d", n, round, key_sel, exp_round);
         end
         checks++;
         if (eval_s !== exp_eval || precharge !== !exp_eval || state_we !== exp_eval) begin
            errors++;
            $display("FAIL single_phase c%0d: got eval=%b pre=%b we=%b, want eval=%b", n, eval_s, precharge, state_we, exp_eval);
         end
         checks++;
         if (done !== exp_done || sel_init !== exp_sel || last_round !== exp_last) begin
            errors++;
            $display("FAIL single_ctl c%0d: got done=%b sel=%b last=%b, want %b %b %b",
                     n, done, sel_init, last_round, exp_done, exp_sel, exp_last);
         end
         if (state_we) we_cnt++;
         if (done && done_cyc < 0) done_cyc = n;
         @(negedge clk);
      end
      checks++;
      if (we_cnt != 15 || done_cyc != 31) begin
         errors++;
         $display("FAIL single_totals: got we=%0d done_cycle=%0d, want 15 31", we_cnt, done_cyc);
      end
      $display("single run: state_we pulses=%0d done at cycle %0d", we_cnt, done_cyc);
   endtask

   task automatic test_start_held();
      int done_cnt = 0;
      logic exp_done, exp_ready;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      for (int n = 1; n <= 65; n++) begin
         exp_done  = (n == 31) || (n == 63);
         exp_ready = (n == 32) || (n >= 64);
         checks++;
         if (done !== exp_done || ready !== exp_ready || busy !== !exp_ready) begin
            errors++;
            $display("FAIL held_ctl c%0d: got done=%b ready=%b busy=%b, want %b %b %b",
                     n, done, ready, busy, exp_done, exp_ready, !exp_ready);
         end
         if (n == 33) begin
            checks++;
            if (round !== 4'd0 || sel_init !== 1'b1 || precharge !== 1'b1) begin
               errors++;
               $display("FAIL held_restart: got round=%0d sel=%b pre=%b, want 0 1 1", round, sel_init, precharge);
            end
         end
         if (done && n <= 40) done_cnt++;
         if (n == 40) start = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL held_once: got %0d done pulses in 40 cycles, want 1", done_cnt);
      end
      $display("start held: done pulses in first 40 cycles=%0d", done_cnt);
   endtask

   task automatic test_stretched_phases();
      int we_cnt = 0;
      logic [3:0] exp_round;
      logic exp_eval, exp_we, exp_done;
      int pos;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (int n = 1; n <= 77; n++) begin
         pos       = (n - 1) % 5;
         exp_round = (n <= 75) ? 4'((n - 1) / 5) : ((n == 76) ? 4'd14 : 4'd0);
         exp_eval  = (n <= 75) && (pos >= 2);
         exp_we    = (n <= 75) && (pos == 4);
         exp_done  = (n == 76);
         checks++;
         if (round2 !== exp_round || eval2 !== exp_eval || precharge2 !== !exp_eval) begin
            errors++;
            $display("FAIL stretch_phase c%0d: got round=%0d eval=%b pre=%b, want %0d %b %b",
                     n, round2, eval2, precharge2, exp_round, exp_eval, !exp_eval);
         end
         checks++;
         if (state_we2 !== exp_we || done2 !== exp_done) begin
            errors++;
            $display("FAIL stretch_we c%0d: got we=%b done=%b, want %b %b", n, state_we2, done2, exp_we, exp_done);
         end
         if (state_we2) we_cnt++;
         @(negedge clk);
      end
      checks++;
      if (we_cnt != 15 || ready2 !== 1'b1) begin
         errors++;
         $display("FAIL stretch_totals: got we=%0d ready=%b, want 15 1", we_cnt, ready2);
      end
      $display("stretched run: state_we pulses=%0d", we_cnt);
   endtask

   task automatic test_reset_mid_run();
      int hit = -1;
      int done_cyc = -1;
      int bad = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 1; n <= 40 && hit < 0; n++) begin
         if (round == 4'd7 && eval_s) hit = n;
         else @(negedge clk);
      end
      checks++;
      if (hit != 16) begin
         errors++;
         $display("FAIL midrst_reach: round 7 eval seen at cycle %0d, want 16", hit);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || eval_s !== 1'b0 || precharge !== 1'b1 || round !== 4'd0) begin
         errors++;
         $display("FAIL midrst_idle: got ready=%b busy=%b eval=%b pre=%b round=%0d, want 1 0 0 1 0",
                  ready, busy, eval_s, precharge, round);
      end
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || state_we || busy) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midrst_quiet: got %0d cycles with done/we/busy after reset, want 0", bad);
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int n = 1; n <= 40 && done_cyc < 0; n++) begin
         if (done) done_cyc = n;
         else @(negedge clk);
      end
      checks++;
      if (done_cyc != 31) begin
         errors++;
         $display("FAIL midrst_fresh: got done at cycle %0d, want 31", done_cyc);
      end
      $display("reset mid-run: round 7 eval at %0d, fresh run done at %0d", hit, done_cyc);
      @(negedge clk);
   endtask

   task automatic test_spacer_check();
      logic exp_err, pend;
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      exp_err = 1'b0;
      pend    = 1'b0;
      for (int run = 0; run < 2; run++) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int n = 1; n <= 32; n++) begin
            exp_err = exp_err | pend;
            pend    = 1'b0;
            checks++;
            if (err !== exp_err) begin
               errors++;
               $display("FAIL spacer_err r%0d c%0d: got err=%b, want %b", run, n, err, exp_err);
            end
            checks++;
            if (done !== (n == 31)) begin
               errors++;
               $display("FAIL spacer_done r%0d c%0d: got done=%b, want %b", run, n, done, (n == 31));
            end
            if (eval_s) begin
               dr_t = pat;
               dr_f = ~pat;
               if (run == 1 && round == 4'd3) begin
                  dr_t[5] = 1'b1;
                  dr_f[5] = 1'b1;
`ifdef SPACER_CHECK_EN
                  pend = 1'b1;
`endif
               end
            end else begin
               dr_t = '0;
               dr_f = '0;
            end
            @(negedge clk);
         end
         $display("spacer run %0d: err=%b", run, err);
      end
      dr_t = '0;
      dr_f = '0;
   endtask

   initial begin
      pat = {4{32'hA5C3_0F96}};
      test_reset();
      test_single_run();
      test_start_held();
      test_stretched_phases();
      test_reset_mid_run();
      test_spacer_check();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
